div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one restoring-divider datapath and its control unit between up to four requesters. Grants one request at a time round-robin, latches that requester's operands, pulses the divider's `go`, waits for its `done`, and returns quotient, remainder and error with a one-cycle acknowledge. Sits between the client blocks and the divider top level. Owns the divider's `go` and operand inputs exclusively.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `W`, 4: operand, quotient and remainder width; must match the divider.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `req` in NREQ: request per requester. Held high with operands stable until its `ack`.
- `x_in` in NREQ*W: dividends. Requester i uses bits [i*W +: W].
- `y_in` in NREQ*W: divisors, packed the same way.
- `ack` out NREQ: one-hot, one-cycle pulse. `q`, `r` and `err` are valid in that cycle.
- `q` out W: quotient.
- `r` out W: remainder.
- `err` out 1: divide-by-zero flag.
- `busy` out 1: high in any state other than IDLE.
- `gnt_id` out 2: index of the current or last granted requester.
- `div_go` out 1: start pulse to the divider control unit.
- `div_x` out W: dividend to the divider.
- `div_y` out W: divisor to the divider.
- `div_done` in 1: divider completion pulse, one cycle.
- `div_error` in 1: divider error flag, valid with `div_done`.
- `div_q` in W: divider quotient, valid with `div_done`.
- `div_r` in W: divider remainder, valid with `div_done`.

## Operation
- **FSM states:** IDLE, ISSUE, BUSY, RESP.
- **IDLE:** if any `req` is high, choose the winner round-robin:
  - Search starts at index `last+1` mod NREQ.
  - Latch the winner's `x`/`y` into `div_x`/`div_y`.
  - Set `gnt_id` to the winner and update `last`.
  - Go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:** `div_go`=1 for exactly this one cycle, then go to BUSY.
- **BUSY:** hold `div_x`/`div_y` stable.
  - On `div_done`=1, register `div_q`, `div_r` and `div_error` into `q`, `r` and `err`, then go to RESP.
  - Otherwise stay in BUSY.
- **RESP:** `ack[gnt_id]`=1 for one cycle, then go to IDLE.
- `q`, `r` and `err` hold their values until the next capture.
- **Operand width:** operands pass through unmodified at W bits. No arithmetic is performed in this block.
- **Requester drops `req` before `ack`:** the operation still completes and `ack` still pulses. The requester discards the result.
- **`div_done` outside BUSY:** ignored.
- **Requests during an operation:** new or held requests wait. They are evaluated only in IDLE.
- **Re-request right after `ack`:** a requester that raises `req` again immediately is served only after every other pending requester has had one grant.

## Timing
- **Reset values:** after `rst`, state=IDLE, `last`=NREQ-1 (so requester 0 has first priority), and all outputs are 0: `ack`, `q`, `r`, `err`, `busy`, `gnt_id`, `div_go`, `div_x`, `div_y`.
- **Reset mid-operation:** on the next edge the block returns to IDLE and `div_go` drops.
  - The divider shares `rst`, so it aborts too.
  - No `ack` is issued for the aborted request.
- **Latency:** `req` sampled at edge N in IDLE gives:
  - `div_go` high in cycle N+1.
  - `ack` at cycle D+2, where D is the cycle in which `div_done` is seen.
  - Minimum back-to-back throughput is one result per (divider latency + 3) cycles.

## Configuration
- **`DIV_ARB_ZERO_BYPASS_EN` defined:** in IDLE, a winner whose divisor is 0 skips ISSUE and BUSY.
  - The block goes straight to RESP with `q`=0, `r`=0, `err`=1.
  - `div_go` is never pulsed.
  - `ack` comes 2 cycles after the `req` sample.
- **Undefined:** a zero divisor is forwarded to the divider, and `err` mirrors `div_error` captured at `div_done`.

## Structure
- **Package `div_arb_pkg`:**
  - State encoding localparams: IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2, RESP=2'd3.
  - Default W=4.
  - Max NREQ=4.
- **Sub-module `rr_arbiter`:** combinational round-robin pick.
  - Inputs: `req` and `last`.
  - Outputs: `win_id` and `any_req`.
  - The FSM, operand registers and result registers stay in `div_arbiter`.

## Test plan
- **Single request:** requester 0 asserts `x`=13, `y`=4.
  - `div_go` pulses once.
  - `ack[0]` pulses with `q`=3, `r`=1, `err`=0.
  - `busy` is high from ISSUE through RESP.
- **Contention:** `req`=2'b11 held continuously with NREQ=2.
  - Grants alternate 0,1,0,1.
  - Each `ack` carries that requester's result: 9/3 gives q=3, r=0; 7/2 gives q=3, r=1.
- **Zero divisor:** `y`=0, `x`=5.
  - With the macro: `ack` and `err`=1 after 2 cycles, `q`=0, `r`=0, no `div_go`.
  - Without the macro: `div_go` is issued and `err` equals the divider's error.
- **Reset mid-operation:** assert `rst` in BUSY.
  - Next cycle: IDLE, all outputs 0, no `ack`.
  - A new request afterwards is served by requester 0 first.
- **Early drop:** `req[1]` drops during BUSY.
  - `ack[1]` still pulses once.
  - The FSM returns to IDLE with no hang.
- **Spurious done:** `div_done` pulsed while in IDLE with no request.
  - No state change, no `ack`, and `q`/`r` are unchanged.

Source files
------------

// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared FSM encoding and size defaults for the divider arbiter
package div_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, RESP = 2'd3} state_e;
    localparam int W_DEF = 4;
    localparam int NREQ_MAX = 4;
endpackage

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester and divider-side signals of the arbiter
interface div_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W = W_DEF
);
    logic [NREQ-1:0] req, ack;
    logic [NREQ*W-1:0] x_in, y_in;
    logic [W-1:0] q, r, div_x, div_y, div_q, div_r;
    logic err, busy, div_go, div_done, div_error;
    logic [1:0] gnt_id;
    modport slave (
        input req, x_in, y_in, div_done, div_error, div_q, div_r,
        output ack, q, r, err, busy, gnt_id, div_go, div_x, div_y
    );
    modport master (
        output req, x_in, y_in, div_done, div_error, div_q, div_r,
        input ack, q, r, err, busy, gnt_id, div_go, div_x, div_y
    );
endinterface

// File: rtl/div_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last winner
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      win_id,
    output logic            any_req
);
    always_comb begin
        int best, ofs;
        best = NREQ;
        ofs = 0;
        win_id = '0;
        any_req = |req;
        for (int j = 0; j < NREQ; j++) begin
            ofs = (j + NREQ - 1 - int'(last)) % NREQ;
            if (req[j] && ofs < best) begin
                best = ofs;
                win_id = 2'(j);
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one divider; DIV_ARB_ZERO_BYPASS_EN answers zero divisors locally
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W = W_DEF
) (
    input logic clk,
    input logic rst,
    div_arbiter_if.slave bus
);
    state_e state_q, state_d;
    logic [1:0] last_q, last_d, gnt_q, gnt_d, win_id;
    logic [W-1:0] x_q, x_d, y_q, y_d, quo_q, quo_d, rem_q, rem_d, win_x, win_y;
    logic err_q, err_d, go_q, go_d, busy_q, busy_d, any_req;
    logic [NREQ-1:0] ack_q, ack_d, req_m;
    // the acked requester still shows its old request during the ack cycle
    assign req_m = bus.req & ~ack_q;
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req(req_m),
        .last(last_q),
        .win_id(win_id),
        .any_req(any_req)
    );
    assign win_x = bus.x_in[int'(win_id)*W +: W];
    assign win_y = bus.y_in[int'(win_id)*W +: W];
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        gnt_d = gnt_q;
        x_d = x_q;
        y_d = y_q;
        quo_d = quo_q;
        rem_d = rem_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (any_req) begin
                gnt_d = win_id;
                last_d = win_id;
                x_d = win_x;
                y_d = win_y;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                state_d = (win_y == '0) ? RESP : ISSUE;
                if (win_y == '0) begin
                    quo_d = '0;
                    rem_d = '0;
                    err_d = 1'b1;
                end
`else
                state_d = ISSUE;
`endif
            end
            ISSUE: state_d = BUSY;
            BUSY: if (bus.div_done) begin
                quo_d = bus.div_q;
                rem_d = bus.div_r;
                err_d = bus.div_error;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
        ack_d = (state_q == RESP) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_q : '0;
        go_d = state_d == ISSUE;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= 2'(NREQ - 1);
            gnt_q <= '0;
            x_q <= '0;
            y_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
            go_q <= 1'b0;
            busy_q <= 1'b0;
            ack_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            gnt_q <= gnt_d;
            x_q <= x_d;
            y_q <= y_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            err_q <= err_d;
            go_q <= go_d;
            busy_q <= busy_d;
            ack_q <= ack_d;
        end
    end
    assign bus.ack = ack_q;
    assign bus.q = quo_q;
    assign bus.r = rem_q;
    assign bus.err = err_q;
    assign bus.busy = busy_q;
    assign bus.gnt_id = gnt_q;
    assign bus.div_go = go_q;
    assign bus.div_x = x_q;
    assign bus.div_y = y_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed checks of the arbiter with a hand-driven divider
module tb_div_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int ntot = 0;
    int npass = 0;
    div_arbiter_if #(.NREQ(2), .W(4)) bus ();
    div_arbiter #(.NREQ(2), .W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    // one full grant: issue, two busy cycles, done, resp, ack
    task automatic op(input logic [1:0] g, input logic [3:0] xv, input logic [3:0] yv,
                      input logic [3:0] qv, input logic [3:0] rv, input logic e, input logic drop);
        cyc();
        chk("issue_go", bus.div_go, 1);
        chk("issue_gnt", bus.gnt_id, g);
        chk("issue_x", bus.div_x, xv);
        chk("issue_y", bus.div_y, yv);
        cyc();
        chk("busy_go", bus.div_go, 0);
        chk("busy_busy", bus.busy, 1);
        if (drop) bus.req = 2'b00;
        cyc();
        chk("busy_hold_x", bus.div_x, xv);
        bus.div_done = 1'b1;
        bus.div_q = qv;
        bus.div_r = rv;
        bus.div_error = e;
        cyc();
        bus.div_done = 1'b0;
        chk("resp_busy", bus.busy, 1);
        chk("resp_noack", bus.ack, 0);
        cyc();
        chk("ack", bus.ack, 2'b01 << g);
        chk("ack_q", bus.q, qv);
        chk("ack_r", bus.r, rv);
        chk("ack_err", bus.err, e);
        chk("ack_idle", bus.busy, 0);
    endtask
    initial begin
        bus.req = '0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.div_done = 1'b0;
        bus.div_error = 1'b0;
        bus.div_q = '0;
        bus.div_r = '0;
        cyc();
        cyc();
        chk("rst_outs", {bus.ack, bus.q, bus.r, bus.err, bus.busy, bus.gnt_id, bus.div_go, bus.div_x, bus.div_y}, 0);
        rst = 1'b0;
        bus.req = 2'b01;
        bus.x_in = {4'd0, 4'd13};
        bus.y_in = {4'd0, 4'd4};
        op(2'd0, 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b0);
        bus.req = 2'b00;
        cyc();
        chk("after_ack_idle", bus.busy, 0);
        chk("after_ack_go", bus.div_go, 0);
        bus.div_done = 1'b1;
        bus.div_q = 4'd9;
        bus.div_r = 4'd7;
        bus.div_error = 1'b1;
        cyc();
        bus.div_done = 1'b0;
        chk("spur_busy", bus.busy, 0);
        chk("spur_ack", bus.ack, 0);
        chk("spur_q", bus.q, 3);
        chk("spur_r", bus.r, 1);
        chk("spur_err", bus.err, 0);
        bus.req = 2'b10;
        bus.x_in = {4'd6, 4'd0};
        bus.y_in = {4'd2, 4'd0};
        cyc();
        chk("rr_gnt1", bus.gnt_id, 1);
        chk("rr_go", bus.div_go, 1);
        cyc();
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        bus.req = 2'b00;
        cyc();
        chk("midrst_outs", {bus.ack, bus.q, bus.r, bus.err, bus.busy, bus.gnt_id, bus.div_go, bus.div_x, bus.div_y}, 0);
        rst = 1'b0;
        cyc();
        chk("midrst_noack", bus.ack, 0);
        chk("midrst_idle", bus.busy, 0);
        bus.req = 2'b11;
        bus.x_in = {4'd7, 4'd9};
        bus.y_in = {4'd2, 4'd3};
        op(2'd0, 4'd9, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0);
        op(2'd1, 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0);
        op(2'd0, 4'd9, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0);
        op(2'd1, 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0);
        bus.req = 2'b10;
        cyc();
        chk("stale_req_ignored", bus.busy, 0);
        op(2'd1, 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b1);
        cyc();
        chk("drop_idle", bus.busy, 0);
        chk("drop_single_ack", bus.ack, 0);
        bus.req = 2'b01;
        bus.x_in = {4'd7, 4'd5};
        bus.y_in = {4'd2, 4'd0};
`ifdef DIV_ARB_ZERO_BYPASS_EN
        cyc();
        chk("zb_go", bus.div_go, 0);
        chk("zb_busy", bus.busy, 1);
        cyc();
        chk("zb_ack", bus.ack, 2'b01);
        chk("zb_q", bus.q, 0);
        chk("zb_r", bus.r, 0);
        chk("zb_err", bus.err, 1);
        chk("zb_nogo", bus.div_go, 0);
`else
        op(2'd0, 4'd5, 4'd0, 4'd15, 4'd5, 1'b1, 1'b0);
`endif
        bus.req = 2'b00;
        cyc();
        chk("end_idle", bus.busy, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
